// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage integer divider: default width and FSM encoding.
package div_unit_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q_bit
);

    logic [WIDTH:0]   w_part;
    logic [WIDTH-1:0] w_diff;

    assign w_part  = {i_rem, i_bit};
    assign o_q_bit = (w_part >= {1'b0, i_divisor});
    // Remainder stays below the divisor, so the low WIDTH bits of the difference are exact.
    assign w_diff  = w_part[WIDTH-1:0] - i_divisor;
    assign o_rem   = o_q_bit ? w_diff : w_part[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the EX stage; stalls the pipeline while iterating.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_signed_div,
    input  logic             i_annul,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_stall,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic             o_div_by_zero
);

    localparam int unsigned CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : $clog2(WIDTH);

    div_state_e       r_state;
    div_state_e       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic             r_sign_q;
    logic             r_sign_r;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_dbz;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_q_final;
    logic             w_last;
    logic             w_b_zero;

    assign w_abs_a   = (i_signed_div && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_abs_b   = (i_signed_div && i_b[WIDTH-1]) ? -i_b : i_b;
    assign w_b_zero  = (i_b == '0);
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
    // Quotient bits shift into the dividend register as its bits are consumed.
    assign w_q_final = {r_dvd[WIDTH-2:0], w_q_bit};

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_dvd[WIDTH-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_rem_next),
        .o_q_bit   (w_q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_stall      = 1'b0;
        o_ready      = 1'b0;
        unique case (r_state)
            DIV_IDLE: begin
                if (i_start && !i_annul) begin
                    o_stall      = 1'b1;
                    w_state_next = w_b_zero ? DIV_DONE : DIV_RUN;
                end
            end
            DIV_RUN: begin
                o_stall = 1'b1;
                if (i_annul) begin
                    w_state_next = DIV_IDLE;
                end else if (w_last) begin
                    w_state_next = DIV_DONE;
                end
            end
            DIV_DONE: begin
                o_ready      = !i_annul;
                w_state_next = DIV_IDLE;
            end
            default: w_state_next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_dbz    <= 1'b0;
        end else begin
            unique case (r_state)
                DIV_IDLE: begin
                    if (i_start && !i_annul) begin
                        if (w_b_zero) begin
                            r_lo  <= '1;
                            r_hi  <= i_a;
                            r_dbz <= 1'b1;
                        end else begin
                            r_cnt    <= '0;
                            r_rem    <= '0;
                            r_dvd    <= w_abs_a;
                            r_dvs    <= w_abs_b;
                            r_sign_q <= i_signed_div & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                            r_sign_r <= i_signed_div & i_a[WIDTH-1];
                        end
                    end
                end
                DIV_RUN: begin
                    if (!i_annul) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        r_rem <= w_rem_next;
                        r_dvd <= w_q_final;
                        if (w_last) begin
                            r_lo  <= r_sign_q ? -w_q_final : w_q_final;
                            r_hi  <= r_sign_r ? -w_rem_next : w_rem_next;
                            r_dbz <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_lo          = r_lo;
    assign o_hi          = r_hi;
    assign o_div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized operands against a model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic        annul;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    logic        ready;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_unit #(
        .WIDTH (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (start),
        .i_signed_div  (signed_div),
        .i_annul       (annul),
        .i_a           (a),
        .i_b           (b),
        .o_stall       (stall),
        .o_ready       (ready),
        .o_lo          (lo),
        .o_hi          (hi),
        .o_div_by_zero (dbz)
    );

    // Reference: 64-bit arithmetic, so the signed overflow case needs no special handling.
    function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input bit ms,
                                  output logic [31:0] elo, output logic [31:0] ehi,
                                  output bit edz);
        longint xa;
        longint xb;
        if (mb == 32'd0) begin
            elo = 32'hFFFF_FFFF;
            ehi = ma;
            edz = 1'b1;
        end else begin
            if (ms) begin
                xa = longint'($signed(ma));
                xb = longint'($signed(mb));
            end else begin
                xa = longint'({32'd0, ma});
                xb = longint'({32'd0, mb});
            end
            elo = 32'(xa / xb);
            ehi = 32'(xa % xb);
            edz = 1'b0;
        end
    endfunction

    // Issues one division, holding start like a frozen pipeline, and measures the handshake.
    task automatic run_div(input logic [31:0] ta, input logic [31:0] tb_v, input bit ts,
                           output int rdy_cyc, output int stall_cnt);
        rdy_cyc   = -1;
        stall_cnt = 0;
        @(posedge clk);
        #1;
        start      = 1'b1;
        a          = ta;
        b          = tb_v;
        signed_div = ts;
        annul      = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (ready) begin
                rdy_cyc = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({lo, hi, dbz, stall, ready} !== 67'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got lo=%h hi=%h dbz=%b stall=%b ready=%b want all 0",
                     lo, hi, dbz, stall, ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_divu_basic();
        int rc, sc;
        run_div(32'd100, 32'd7, 1'b0, rc, sc);
        n_cmp++;
        if (rc !== 33) begin n_err++; $display("FAIL divu_latency: got %0d want 33", rc); end
        n_cmp++;
        if (sc !== 33) begin n_err++; $display("FAIL divu_stall_cycles: got %0d want 33", sc); end
        n_cmp++;
        if ({lo, hi, dbz} !== {32'd14, 32'd2, 1'b0}) begin
            n_err++;
            $display("FAIL divu_100_7: got lo=%0d hi=%0d dbz=%b want 14 2 0", lo, hi, dbz);
        end
    endtask

    task automatic test_signed();
        logic [31:0] ta [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'd7};
        logic [31:0] tb [4] = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        bit          ts [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] el [4] = '{32'hFFFF_FFFD, 32'h7FFF_FFFC, 32'h8000_0000, 32'hFFFF_FFFD};
        logic [31:0] eh [4] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1};
        int rc, sc;
        for (int i = 0; i < 4; i++) begin
            run_div(ta[i], tb[i], ts[i], rc, sc);
            n_cmp++;
            if (rc !== 33 || lo !== el[i] || hi !== eh[i] || dbz !== 1'b0) begin
                n_err++;
                $display("FAIL signed_case%0d: got lat=%0d lo=%h hi=%h dbz=%b want 33 %h %h 0",
                         i, rc, lo, hi, dbz, el[i], eh[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int rc, sc;
        run_div(32'h1234, 32'd0, 1'b0, rc, sc);
        n_cmp++;
        if (rc !== 1 || sc !== 1) begin
            n_err++;
            $display("FAIL div0_timing: got ready@%0d stall=%0d want 1 1", rc, sc);
        end
        n_cmp++;
        if ({lo, hi, dbz} !== {32'hFFFF_FFFF, 32'h1234, 1'b1}) begin
            n_err++;
            $display("FAIL div0_result: got lo=%h hi=%h dbz=%b want ffffffff 00001234 1",
                     lo, hi, dbz);
        end
    endtask

    task automatic test_annul();
        int rc, sc, n_rdy;
        run_div(32'd9, 32'd4, 1'b0, rc, sc);
        n_cmp++;
        if ({lo, hi} !== {32'd2, 32'd1}) begin
            n_err++;
            $display("FAIL annul_pre: got lo=%0d hi=%0d want 2 1", lo, hi);
        end
        @(posedge clk);
        #1;
        start = 1'b1; a = 32'd100; b = 32'd7; signed_div = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        annul = 1'b1;
        @(posedge clk);
        #1;
        annul = 1'b0; start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({stall, ready, lo, hi} !== {1'b0, 1'b0, 32'd2, 32'd1}) begin
            n_err++;
            $display("FAIL annul_run: got stall=%b ready=%b lo=%0d hi=%0d want 0 0 2 1",
                     stall, ready, lo, hi);
        end
        n_rdy = 0;
        repeat (40) begin @(negedge clk); if (ready) n_rdy++; end
        n_cmp++;
        if (n_rdy !== 0) begin n_err++; $display("FAIL annul_no_ready: got %0d want 0", n_rdy); end
        run_div(32'd20, 32'd3, 1'b0, rc, sc);
        n_cmp++;
        if (rc !== 33 || lo !== 32'd6 || hi !== 32'd2) begin
            n_err++;
            $display("FAIL annul_after: got lat=%0d lo=%0d hi=%0d want 33 6 2", rc, lo, hi);
        end
    endtask

    task automatic test_reset_mid_run();
        int rc, sc;
        @(posedge clk);
        #1;
        start = 1'b1; a = 32'd100; b = 32'd7; signed_div = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1; start = 1'b0;
        #1;
        n_cmp++;
        if ({lo, hi, stall, ready, dbz} !== 67'd0) begin
            n_err++;
            $display("FAIL reset_mid_run: got lo=%h hi=%h stall=%b ready=%b dbz=%b want all 0",
                     lo, hi, stall, ready, dbz);
        end
        @(negedge clk);
        rst = 1'b0;
        run_div(32'd9, 32'd4, 1'b0, rc, sc);
        n_cmp++;
        if (rc !== 33 || lo !== 32'd2 || hi !== 32'd1) begin
            n_err++;
            $display("FAIL reset_then_9_4: got lat=%0d lo=%0d hi=%0d want 33 2 1", rc, lo, hi);
        end
    endtask

    task automatic test_back_to_back();
        int rc, sc;
        run_div(32'd1000, 32'd10, 1'b0, rc, sc);
        run_div(32'hFFFF_FF9C, 32'd9, 1'b1, rc, sc);
        n_cmp++;
        if (rc !== 33 || lo !== 32'hFFFF_FFF5 || hi !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL back_to_back: got lat=%0d lo=%h hi=%h want 33 fffffff5 ffffffff",
                     rc, lo, hi);
        end
    endtask

    task automatic test_random();
        logic [31:0] ra, rb, elo, ehi;
        bit          rs, edz;
        int          rc, sc, elat;
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'd1;
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, elo, ehi, edz);
            elat = (rb == 32'd0) ? 1 : 33;
            run_div(ra, rb, rs, rc, sc);
            n_cmp++;
            if (rc !== elat || lo !== elo || hi !== ehi || dbz !== edz) begin
                n_err++;
                $display("FAIL random%0d a=%h b=%h s=%b: got lat=%0d lo=%h hi=%h dz=%b want %0d %h %h %b",
                         i, ra, rb, rs, rc, lo, hi, dbz, elat, elo, ehi, edz);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_zero();
        test_annul();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider in the EX stage of the 5-stage MIPS pipeline. Implements DIV and DIVU.
- Operands arrive from the ID/EX pipeline registers. Quotient (LO) and remainder (HI) are forwarded into the EX/MEM register.
- Drives a stall request to the hazard unit while busy, which freezes the IF/ID/EX registers.
- Accepts an annul from the hazard unit so a flushed division is abandoned.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  EX-stage instruction is DIV/DIVU; held high by the frozen pipeline while stalled.
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU.
- annul  input  1  flushE from hazard unit; abandons the current or pending division.
- a  input  WIDTH  dividend (rs value).
- b  input  WIDTH  divisor (rt value).
- stall  output  1  combinational stall request to hazard unit.
- ready  output  1  one-cycle pulse; result valid this cycle.
- lo  output  WIDTH  registered quotient.
- hi  output  WIDTH  registered remainder.
- div_by_zero  output  1  registered flag for the last completed division.

Behaviour:
- States: IDLE, RUN, DONE. Reset (async) -> IDLE, clearing count and working registers. Reset values: lo=0, hi=0, div_by_zero=0, ready=0, stall=0.
- IDLE with start=1, annul=0 and b!=0: latch |a|, |b|, sign_q=signed_div&(a[MSB]^b[MSB]) and sign_r=signed_div&a[MSB]. Clear count. Go to RUN.
  - Absolute values are taken only when signed_div=1; otherwise operands are used as-is.
- IDLE with start=1, annul=0 and b==0: go directly to DONE. On that edge load lo=all ones, hi=a, div_by_zero=1.
- RUN: restoring division, one quotient bit per cycle, MSB first.
  - Per step: partial remainder {r[WIDTH-1:0], dividend MSB} is compared with the divisor; subtract if greater or equal. Partial remainder is WIDTH+1 bits wide.
  - After WIDTH steps (count==WIDTH-1 on the edge): go to DONE.
  - On that edge load lo = sign_q ? -q : q, hi = sign_r ? -r : r, div_by_zero=0.
- DONE: always go to IDLE next cycle. start in DONE is ignored, because it belongs to the completing instruction.
- ready = (state==DONE) & ~annul.
- stall = (state==IDLE & start & ~annul) | (state==RUN).
  - stall is low in DONE so the pipeline advances with the result.
- Latency: start first seen in IDLE at cycle T. stall is high T..T+WIDTH (WIDTH+1 cycles). ready is high at T+WIDTH+1.
  - Divide-by-zero case: stall is high at T only, ready at T+1.
- Back-to-back divisions: the next start is sampled in IDLE at T+WIDTH+2 at the earliest.
- annul has priority over start in IDLE. annul in RUN: go to IDLE next cycle; lo, hi and div_by_zero are not updated. annul in DONE suppresses ready, but the registered results are already updated.
- Signed overflow (0x80000000 / -1): the natural result is lo=0x80000000, hi=0; no special case.
- lo, hi and div_by_zero hold their values until the next completion; annul and idle cycles do not change them.
- Reset mid-RUN: IDLE immediately, all outputs 0, no ready.

Decomposition:
- Shared cpu package: state encodings (DIV_IDLE, DIV_RUN, DIV_DONE), WIDTH default 32, count width $clog2(WIDTH).
- One combinational sub-module div_step: inputs partial remainder, dividend bit and divisor; outputs next remainder and quotient bit. Instantiated once inside div_unit.

Test Plan:
- DIVU a=100, b=7, start at T: stall high T..T+32, ready at T+33 -> lo=14, hi=2, div_by_zero=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Same inputs with DIVU -> lo=0x7FFFFFFC, hi=1.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIV a=7, b=0xFFFFFFFE (-2) -> lo=0xFFFFFFFD, hi=1.
- DIVU a=0x1234, b=0 at T: stall high only at T, ready at T+1 -> lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1.
- Start 100/7, assert annul on the 10th RUN cycle:
  - Required: stall low the next cycle, no ready, lo/hi keep their previous values.
  - Then DIVU 20/3 -> lo=6, hi=2, ready 33 cycles after its start.
- Assert rst mid-RUN -> lo=hi=0, stall=0, ready=0 immediately. A new 9/4 after release -> lo=2, hi=1.
